// File: rtl/medidor_faixa_multi_pkg.sv
// Shared types and constants for the multi-channel range meter:
// FSM state codes, ASCII framing characters and a width helper.
package medidor_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    MEDIR      = 4'd1,
    ESPERA     = 4'd2,
    AVALIA     = 4'd3,
    TX_PARTIDA = 4'd4,
    TX_ESPERA  = 4'd5,
    PROX       = 4'd6
  } estado_t;

  localparam logic [6:0] ASCII_HASH   = 7'h23;
  localparam logic [6:0] ASCII_DASH   = 7'h2D;
  localparam logic [6:0] ASCII_ZERO   = 7'h30;
  localparam logic [2:0] DIGIT_PREFIX = 3'b011;

  // Counter width able to hold values 0..n-1, never below one bit.
  function automatic int largura(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] ascii_digit(input logic [3:0] d);
    return {DIGIT_PREFIX, d};
  endfunction

endpackage

// File: rtl/medidor_faixa_multi_if.sv
// Measurement and serial-TX handshake bundle between the range meter
// (master) and the sensor mux / 7E1 transmitter (slave).
interface medidor_faixa_multi_if #(
  parameter int W  = 12,
  parameter int CW = 1
);

  logic          medir;
  logic [CW-1:0] canal;
  logic [W-1:0]  medida;
  logic          pronto_medida;
  logic          tx_partida;
  logic [6:0]    tx_dados;
  logic          tx_pronto;

  modport master (
    output medir, canal, tx_partida, tx_dados,
    input  medida, pronto_medida, tx_pronto
  );

  modport slave (
    input  medir, canal, tx_partida, tx_dados,
    output medida, pronto_medida, tx_pronto
  );

endinterface

// File: rtl/medidor_faixa_multi_canal_faixa.sv
// One channel's window tracker: last valid sample, miss debounce,
// in-window flag and dwell timer that raises acertou.
module canal_faixa
  import medidor_pkg::*;
#(
  parameter int W     = 12,
  parameter int MISS  = 3,
  parameter int DWELL = 150_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         upd,
  input  logic         valido,
  input  logic [W-1:0] medida,
  input  logic [W-1:0] upper,
  input  logic [W-1:0] lower,
  output logic         dentro,
  output logic         acertou,
  output logic [W-1:0] db_medida
);

  localparam int MW  = largura(MISS + 1);
  localparam int DWW = largura(DWELL);
  localparam logic [MW-1:0]  MISS_MAX  = MW'(MISS);
  localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL - 1);

  logic [W-1:0]   medida_reg;
  logic [MW-1:0]  miss_reg;
  logic [MW-1:0]  miss_next;
  logic [DWW-1:0] dwell_reg;
  logic           dentro_reg;
  logic           na_janela;

  // Inverted limits can never satisfy both bounds, so no special case needed.
  assign na_janela = (medida >= lower) && (medida <= upper);
  assign miss_next = (miss_reg == MISS_MAX) ? miss_reg : miss_reg + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      medida_reg <= '0;
      miss_reg   <= '0;
      dentro_reg <= 1'b0;
      dwell_reg  <= '0;
    end else if (zera) begin
      medida_reg <= '0;
      miss_reg   <= '0;
      dentro_reg <= 1'b0;
      dwell_reg  <= '0;
    end else begin
      if (upd) begin
        if (valido) begin
          medida_reg <= medida;
        end
        if (valido && na_janela) begin
          dentro_reg <= 1'b1;
          miss_reg   <= '0;
        end else begin
          miss_reg <= miss_next;
          if (miss_next == MISS_MAX) begin
            dentro_reg <= 1'b0;
          end
        end
      end

      if (!dentro_reg) begin
        dwell_reg <= '0;
      end else if (dwell_reg != DWELL_MAX) begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  assign dentro    = dentro_reg;
  assign acertou   = dentro_reg && (dwell_reg == DWELL_MAX);
  assign db_medida = medida_reg;

endmodule

// File: rtl/medidor_faixa_multi.sv
// Round-robin multi-channel range meter: sequences measurements over a shared
// sensor interface, tracks each channel's window and frames results as ASCII.
module medidor_faixa_multi
  import medidor_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int DIGITS  = 3,
  parameter int PERIOD  = 12_500_000,
  parameter int DWELL   = 150_000_000,
  parameter int MISS    = 3,
  parameter int TIMEOUT = 2_000_000,
  localparam int W      = 4 * DIGITS,
  localparam int CW     = largura(N_CH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                zera,
  input  logic                ligar,
  input  logic [N_CH*W-1:0]   upperL,
  input  logic [N_CH*W-1:0]   lowerL,
  medidor_faixa_multi_if.master bus,
  output logic [N_CH-1:0]     dentro,
  output logic [N_CH-1:0]     acertou,
  output logic [N_CH*W-1:0]   db_medida,
  output logic [3:0]          db_estado
);

  localparam int TW  = largura(PERIOD);
  localparam int TOW = largura(TIMEOUT);
  localparam int CHW = largura(DIGITS + 2);
  localparam logic [TW-1:0]  TICK_MAX   = TW'(PERIOD - 1);
  localparam logic [TOW-1:0] TMO_MAX    = TOW'(TIMEOUT - 1);
  localparam logic [CHW-1:0] CHAR_LAST  = CHW'(DIGITS + 1);
  localparam logic [CW-1:0]  CANAL_LAST = CW'(N_CH - 1);

  estado_t        estado_reg, estado_next;
  logic [CW-1:0]  canal_reg, canal_next;
  logic [CHW-1:0] char_reg, char_next;
  logic [TOW-1:0] tmo_reg, tmo_next;
  logic [W-1:0]   sample_reg, sample_next;
  logic           timed_out_reg, timed_out_next;
  logic [TW-1:0]  tick_reg;
  logic           pending_reg;
  logic           pend_clr;
  logic           upd;
  logic [3:0]     digito [DIGITS];
  logic [3:0]     digito_sel;
  logic [6:0]     tx_char;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg    <= IDLE;
      canal_reg     <= '0;
      char_reg      <= '0;
      tmo_reg       <= '0;
      sample_reg    <= '0;
      timed_out_reg <= 1'b0;
      tick_reg      <= '0;
      pending_reg   <= 1'b0;
    end else if (zera) begin
      estado_reg    <= IDLE;
      canal_reg     <= '0;
      char_reg      <= '0;
      tmo_reg       <= '0;
      sample_reg    <= '0;
      timed_out_reg <= 1'b0;
      tick_reg      <= '0;
      pending_reg   <= 1'b0;
    end else begin
      estado_reg    <= estado_next;
      canal_reg     <= canal_next;
      char_reg      <= char_next;
      tmo_reg       <= tmo_next;
      sample_reg    <= sample_next;
      timed_out_reg <= timed_out_next;
      if (ligar) begin
        tick_reg <= (tick_reg == TICK_MAX) ? '0 : tick_reg + 1'b1;
      end
      // A wrap in the same cycle the round starts keeps the next round pending.
      if (ligar && (tick_reg == TICK_MAX)) begin
        pending_reg <= 1'b1;
      end else if (pend_clr) begin
        pending_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    estado_next    = estado_reg;
    canal_next     = canal_reg;
    char_next      = char_reg;
    tmo_next       = tmo_reg;
    sample_next    = sample_reg;
    timed_out_next = timed_out_reg;
    pend_clr       = 1'b0;
    upd            = 1'b0;
    case (estado_reg)
      IDLE: begin
        canal_next = '0;
        if (pending_reg && ligar) begin
          pend_clr    = 1'b1;
          estado_next = MEDIR;
        end
      end
      MEDIR: begin
        tmo_next    = '0;
        estado_next = ESPERA;
      end
      ESPERA: begin
        if (bus.pronto_medida) begin
          sample_next    = bus.medida;
          timed_out_next = 1'b0;
          estado_next    = AVALIA;
        end else if (tmo_reg == TMO_MAX) begin
          timed_out_next = 1'b1;
          estado_next    = AVALIA;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      AVALIA: begin
        upd         = 1'b1;
        char_next   = '0;
        estado_next = TX_PARTIDA;
      end
      TX_PARTIDA: begin
        estado_next = TX_ESPERA;
      end
      TX_ESPERA: begin
        if (bus.tx_pronto) begin
          if (char_reg == CHAR_LAST) begin
            estado_next = PROX;
          end else begin
            char_next   = char_reg + 1'b1;
            estado_next = TX_PARTIDA;
          end
        end
      end
      PROX: begin
        if ((canal_reg == CANAL_LAST) || !ligar) begin
          estado_next = IDLE;
        end else begin
          canal_next  = canal_reg + 1'b1;
          estado_next = MEDIR;
        end
      end
      default: estado_next = IDLE;
    endcase
  end

  // digito[0] is the most significant BCD digit, sent right after the channel id.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digito
    assign digito[gi] = sample_reg[(DIGITS - 1 - gi)*4 +: 4];
  end

  always_comb begin
    digito_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (char_reg == CHW'(i + 1)) begin
        digito_sel = digito[i];
      end
    end
  end

  always_comb begin
    tx_char = ASCII_HASH;
    if (char_reg == '0) begin
      tx_char = ASCII_ZERO + 7'(canal_reg);
    end else if (char_reg <= CHW'(DIGITS)) begin
      tx_char = timed_out_reg ? ASCII_DASH : ascii_digit(digito_sel);
    end
  end

  assign bus.medir      = (estado_reg == MEDIR);
  assign bus.tx_partida = (estado_reg == TX_PARTIDA);
  assign bus.tx_dados   = ((estado_reg == TX_PARTIDA) || (estado_reg == TX_ESPERA)) ? tx_char : 7'd0;
  assign bus.canal      = canal_reg;
  assign db_estado      = estado_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_canal
    logic upd_ch;
    assign upd_ch = upd && (canal_reg == CW'(gi));

    canal_faixa #(
      .W    (W),
      .MISS (MISS),
      .DWELL(DWELL)
    ) u_canal (
      .clock    (clock),
      .reset    (reset),
      .zera     (zera),
      .upd      (upd_ch),
      .valido   (!timed_out_reg),
      .medida   (sample_reg),
      .upper    (upperL[gi*W +: W]),
      .lower    (lowerL[gi*W +: W]),
      .dentro   (dentro[gi]),
      .acertou  (acertou[gi]),
      .db_medida(db_medida[gi*W +: W])
    );
  end

endmodule

// File: tb/tb_medidor_faixa_multi.sv
// Directed bench for medidor_faixa_multi: table of per-sample vectors plus
// hand sequences for dwell timing, ligar drop, reset and zera mid-frame.
module tb_medidor_faixa_multi;

  logic        clock;
  logic        reset;
  logic        zera;
  logic        ligar;
  logic [23:0] upperL;
  logic [23:0] lowerL;
  logic [1:0]  dentro;
  logic [1:0]  acertou;
  logic [23:0] db_medida;
  logic [3:0]  db_estado;

  int total = 0;
  int bad   = 0;

  medidor_faixa_multi_if #(.W(12), .CW(1)) bus ();

  medidor_faixa_multi #(
    .N_CH(2), .DIGITS(3), .PERIOD(50), .DWELL(20), .MISS(2), .TIMEOUT(100)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .zera     (zera),
    .ligar    (ligar),
    .upperL   (upperL),
    .lowerL   (lowerL),
    .bus      (bus),
    .dentro   (dentro),
    .acertou  (acertou),
    .db_medida(db_medida),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          ch;
    logic [11:0] med;
    bit          resp;
    logic [11:0] lo;
    logic [11:0] up;
    logic [39:0] frame;
    bit          exp_d;
    logic [11:0] exp_db;
  } samp_t;

  samp_t tab [10];

  function automatic samp_t mk(input int ch, input logic [11:0] med, input bit resp,
                               input logic [11:0] lo, input logic [11:0] up,
                               input logic [39:0] frame, input bit exp_d,
                               input logic [11:0] exp_db);
    samp_t s;
    s.ch = ch; s.med = med; s.resp = resp; s.lo = lo; s.up = up;
    s.frame = frame; s.exp_d = exp_d; s.exp_db = exp_db;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.medir, bus.canal, bus.tx_partida, bus.tx_dados,
                dentro, acertou, db_medida, db_estado});
  endfunction

  // Dwell monitor for channel 0: first dentro rise, first acertou rise,
  // and whether acertou drops together with the first dentro fall.
  int t_d = -1;
  int t_a = -1;
  bit fall_seen = 1'b0;
  bit fall_ok   = 1'b0;
  initial begin
    int  ncyc;
    bit  pd, pa, d, a;
    ncyc = 0; pd = 1'b0; pa = 1'b0;
    forever begin
      @(negedge clock);
      d = dentro[0];
      a = acertou[0];
      if (d && !pd && t_d < 0) t_d = ncyc;
      if (a && !pa && t_a < 0) t_a = ncyc;
      if (!d && pd && t_a >= 0 && !fall_seen) begin
        fall_seen = 1'b1;
        fall_ok   = !a && pa;
      end
      pd = d;
      pa = a;
      ncyc++;
    end
  end

  task automatic run_sample(input samp_t s, input bit drop);
    int         n;
    logic [7:0] ch8;
    if (s.ch == 0) begin
      lowerL[11:0] = s.lo; upperL[11:0] = s.up;
    end else begin
      lowerL[23:12] = s.lo; upperL[23:12] = s.up;
    end
    n = 0;
    while (!bus.medir && n < 300) begin @(negedge clock); n++; end
    chk("medir_seen", 64'(bus.medir), 64'd1);
    chk("canal", 64'(bus.canal), 64'(s.ch));
    @(negedge clock);
    chk("medir_one_cycle", 64'(bus.medir), 64'd0);
    n = 1;
    if (s.resp) begin
      @(negedge clock); n++;
      bus.medida = s.med;
      bus.pronto_medida = 1'b1;
      @(negedge clock); n++;
      bus.pronto_medida = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      while (!bus.tx_partida && n < 400) begin @(negedge clock); n++; end
      if (c == 0 && !s.resp) chk("timeout_latency", 64'(n), 64'd102);
      if (c == 0 && drop) ligar = 1'b0;
      ch8 = s.frame[8*(4-c) +: 8];
      chk("tx_partida", 64'(bus.tx_partida), 64'd1);
      chk("tx_char", 64'(bus.tx_dados), 64'(ch8[6:0]));
      bus.tx_pronto = 1'b1;
      @(negedge clock);
      bus.tx_pronto = 1'b0;
      bus.medida = 12'h987;
      bus.pronto_medida = 1'b1;
      @(negedge clock);
      bus.pronto_medida = 1'b0;
      chk("tx_hold", 64'(bus.tx_dados), 64'(ch8[6:0]));
      bus.tx_pronto = 1'b1;
      @(negedge clock);
      bus.tx_pronto = 1'b0;
      n = 0;
    end
    chk("prox_state", 64'(db_estado), 64'd6);
    chk("dentro", 64'(dentro[s.ch]), 64'(s.exp_d));
    chk("db_medida", 64'(db_medida[s.ch*12 +: 12]), 64'(s.exp_db));
    if (s.ch == 1 || drop) begin
      @(negedge clock);
      chk("idle_after_round", 64'(db_estado), 64'd0);
    end
    $display("sample ch=%0d medida=%h resp=%0b frame=%s dentro=%b db=%h",
             s.ch, s.med, s.resp, s.frame, dentro[s.ch], db_medida[s.ch*12 +: 12]);
  endtask

  task automatic stop_mid_tx(input bit use_reset);
    int n;
    n = 0;
    while (!bus.medir && n < 300) begin @(negedge clock); n++; end
    chk("stop_medir_seen", 64'(bus.medir), 64'd1);
    chk("stop_canal", 64'(bus.canal), 64'd1);
    @(negedge clock);
    @(negedge clock);
    bus.medida = 12'h555;
    bus.pronto_medida = 1'b1;
    @(negedge clock);
    bus.pronto_medida = 1'b0;
    n = 0;
    while (!bus.tx_partida && n < 300) begin @(negedge clock); n++; end
    chk("stop_tx_partida", 64'(bus.tx_partida), 64'd1);
    @(negedge clock);
    chk("stop_in_tx_espera", 64'(db_estado), 64'd5);
    if (use_reset) begin
      reset = 1'b0;
      #1;
      chk("reset_mid_tx_outputs", all_outs(), 64'd0);
      @(negedge clock);
      reset = 1'b1;
    end else begin
      zera = 1'b1;
      @(negedge clock);
      zera = 1'b0;
      chk("zera_mid_tx_outputs", all_outs(), 64'd0);
    end
    $display("stop mid-frame via %s", use_reset ? "reset" : "zera");
  endtask

  initial begin
    int cnt;
    tab[0] = mk(0, 12'h123, 1'b1, 12'h300, 12'h400, "0123#", 1'b0, 12'h123);
    tab[1] = mk(1, 12'h123, 1'b1, 12'h000, 12'h999, "1123#", 1'b1, 12'h123);
    tab[2] = mk(0, 12'h200, 1'b1, 12'h100, 12'h200, "0200#", 1'b1, 12'h200);
    tab[3] = mk(1, 12'h456, 1'b1, 12'h000, 12'h999, "1456#", 1'b1, 12'h456);
    tab[4] = mk(0, 12'h201, 1'b1, 12'h100, 12'h200, "0201#", 1'b1, 12'h201);
    tab[5] = mk(1, 12'h777, 1'b0, 12'h000, 12'h999, "1---#", 1'b1, 12'h456);
    tab[6] = mk(0, 12'h201, 1'b1, 12'h100, 12'h200, "0201#", 1'b0, 12'h201);
    tab[7] = mk(1, 12'h250, 1'b1, 12'h300, 12'h200, "1250#", 1'b0, 12'h250);
    tab[8] = mk(0, 12'h100, 1'b1, 12'h100, 12'h200, "0100#", 1'b1, 12'h100);
    tab[9] = mk(1, 12'h099, 1'b1, 12'h100, 12'h200, "1099#", 1'b0, 12'h099);

    reset = 1'b0; zera = 1'b0; ligar = 1'b0;
    upperL = '0; lowerL = '0;
    bus.medida = '0; bus.pronto_medida = 1'b0; bus.tx_pronto = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b1;
    ligar = 1'b1;

    for (int i = 0; i < 10; i++) run_sample(tab[i], 1'b0);

    chk("acertou_delay", 64'(t_a - t_d), 64'd19);
    chk("acertou_falls_with_dentro", 64'(fall_seen && fall_ok), 64'd1);

    run_sample(mk(0, 12'h150, 1'b1, 12'h100, 12'h200, "0150#", 1'b1, 12'h150), 1'b1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.medir) cnt++;
    end
    chk("no_medir_after_drop", 64'(cnt), 64'd0);
    chk("idle_after_drop", 64'(db_estado), 64'd0);
    $display("ligar drop: medir pulses while off=%0d", cnt);

    ligar = 1'b1;
    run_sample(mk(0, 12'h321, 1'b1, 12'h000, 12'h999, "0321#", 1'b1, 12'h321), 1'b0);
    stop_mid_tx(1'b1);
    run_sample(mk(0, 12'h321, 1'b1, 12'h000, 12'h999, "0321#", 1'b1, 12'h321), 1'b0);
    stop_mid_tx(1'b0);
    run_sample(mk(0, 12'h042, 1'b1, 12'h000, 12'h999, "0042#", 1'b1, 12'h042), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/medidor_faixa_multi.md
# medidor_faixa_multi

Multi-channel successor of the single-sensor range-meter datapath: sequences N_CH ultrasonic channels round-robin through one shared measurement interface, tracks in-window state per channel with miss debouncing and a dwell timer, and reports every sample as an ASCII frame through an external 7E1 serial transmitter. It sits between the HC-SR04 interface/mux and the serial TX, and replaces the separate control FSM of the old datapath.

## Interface
- N_CH, 2: channels, 1..10
- DIGITS, 3: BCD digits per measurement; W = 4*DIGITS
- PERIOD, 12_500_000: cycles between round starts
- DWELL, 150_000_000: in-window cycles before acertou
- MISS, 3: consecutive out-of-window samples needed to clear dentro
- TIMEOUT, 2_000_000: cycles to wait for pronto_medida
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- zera  in  1  synchronous clear, priority over all else
- ligar  in  1  enables rounds
- upperL, lowerL  in  N_CH*W  per-channel BCD limits, channel k at [k*W +: W]
- medir  out  1  one-cycle measurement request
- canal  out  max(1,$clog2(N_CH))  channel selected on the sensor mux
- medida  in  W  BCD result
- pronto_medida  in  1  result-valid pulse
- tx_partida  out  1  one-cycle TX start
- tx_dados  out  7  ASCII character
- tx_pronto  in  1  TX-done pulse
- dentro, acertou  out  N_CH  per-channel status
- db_medida  out  N_CH*W  last valid measurement per channel
- db_estado  out  4  FSM state code

## Operation
- Tick counter runs while ligar=1; at PERIOD-1 it wraps and sets a pending flag. Extra ticks while pending collapse into one.
- FSM: IDLE -> MEDIR -> ESPERA -> AVALIA -> TX_PARTIDA <-> TX_ESPERA -> PROX.
  - IDLE (code 0): leave when pending=1 and ligar=1; clear pending; canal=0.
  - MEDIR: medir=1 for one cycle.
  - ESPERA: wait for pronto_medida; count timeout.
  - AVALIA: one cycle; update the channel tracker.
  - TX_*: send DIGITS+2 characters: '0'+canal, then digits MSD first as {3'b011,digit}, then '#' (0x23). A timed-out sample sends '-' (0x2D) for every digit.
  - PROX: if canal=N_CH-1 or ligar=0, go to IDLE; otherwise increment canal and go to MEDIR.
- Tracker, per channel:
  - Valid sample: register medida into db_medida.
  - Inside the window means lowerL<=medida<=upperL, compared as unsigned BCD. Limits are inclusive. If lowerL>upperL the channel is never inside.
  - Inside sample: set dentro and zero the miss count.
  - Outside or timed-out sample: increment the miss count, saturating. dentro clears when the count reaches MISS.
  - Dwell counter counts every clock while dentro=1, saturates at DWELL-1, and zeroes when dentro=0.
  - acertou = dentro && dwell==DWELL-1.
- zera clears trackers, pending, the tick counter and all counters, and forces IDLE.
- ligar falling mid-round: the current channel's frame completes, then IDLE.

## Timing
- Reset values: all outputs 0, canal 0, db_estado 0, all counters and flags 0.
- medir is high exactly one cycle after leaving IDLE or PROX.
- Timeout fires on the TIMEOUT-th cycle in ESPERA with no pronto_medida. pronto_medida in that same cycle wins.
- pronto_medida outside ESPERA is ignored.
- canal is stable from MEDIR through PROX.
- tx_dados is valid in the tx_partida cycle and held until tx_pronto. tx_pronto is accepted only from the cycle after tx_partida.
- dentro/db_medida update in the cycle after AVALIA.
- Round latency per channel: 1 (MEDIR) + sensor time + 1 (AVALIA) + (DIGITS+2) TX frames + 1 (PROX).
- No TX timeout: a missing tx_pronto stalls the FSM until zera or reset.

## Structure
- Package medidor_pkg holds:
  - the state enum with fixed codes: IDLE=0, MEDIR=1, ESPERA=2, AVALIA=3, TX_PARTIDA=4, TX_ESPERA=5, PROX=6
  - the ASCII constants: hash 0x23, dash 0x2D, digit prefix 3'b011
- Sub-module canal_faixa holds one channel's state: register, miss counter, dentro, dwell counter and acertou. It is generated N_CH times and selected by canal.
- Top holds the FSM, tick counter, character counter and character mux.

## Test plan
Bench parameters: N_CH=2, DIGITS=3, PERIOD=50, DWELL=20, MISS=2, TIMEOUT=100.
- After reset, ligar=1 and medida=0x123 for both channels -> frames "0123#" and "1123#" on tx_dados; one medir pulse per channel; db_estado returns to 0.
- ch0 limits 0x100..0x200, samples 0x200 then 0x201, 0x201 -> dentro set on the boundary sample, held after the first miss, cleared after the second.
- ch0 held in-window with limits 0x050..0x300 -> acertou rises exactly 19 cycles after dentro rises; falls with dentro.
- pronto_medida withheld on ch1 -> timeout after 100 cycles, frame "1---#", db_medida[1] unchanged, miss count +1.
- ligar dropped during ch0 TX -> ch0 frame completes, no ch1 MEDIR, IDLE reached.
- Assert reset mid-TX_ESPERA, and separately zera mid-TX_ESPERA -> all outputs 0 immediately (reset) or next cycle (zera); a subsequent round restarts at canal 0.
